// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and defaults for the FIFO-fed UART transmitter.
// FIFO_UART_TX_PARITY_EN adds an even-parity bit between data and stop.
package fifo_uart_tx_pkg;

  localparam int OVS_TICKS   = 16;
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int DVSR_DEF    = 163;

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// First-word-fall-through FIFO read port seen by the transmitter.
// No configuration macros affect this file.
interface fifo_uart_tx_if
  import fifo_uart_tx_pkg::*;
  #(parameter int DBIT = DBIT_DEF);

  logic            fifo_empty;
  logic [DBIT-1:0] fifo_r_data;
  logic            fifo_rd;

  modport master (output fifo_empty, output fifo_r_data, input fifo_rd);
  modport slave  (input fifo_empty, input fifo_r_data, output fifo_rd);

endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Oversample tick generator: one-cycle s_tick every DVSR clocks, restartable.
// No configuration macros affect this file.
module baud_gen
  import fifo_uart_tx_pkg::*;
  #(parameter int DVSR = DVSR_DEF)
  (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic s_tick
  );

  localparam int              CW   = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [CW-1:0]   LAST = CW'(DVSR - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset || clr) cnt_q <= '0;
    else if (cnt_q == LAST) cnt_q <= '0;
    else cnt_q <= cnt_q + 1'b1;
  end

  assign s_tick = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a FWFT FIFO, frames sent back-to-back.
// FIFO_UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for fifo_empty=0
// START  | start bit (tx=0), 16 ticks
// DATA   | DBIT data bits LSB first, 16 ticks each
// PARITY | even parity of loaded word, 16 ticks (parity build only)
// STOP   | stop bit (tx=1), SB_TICK ticks; reloads directly if FIFO not empty
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
  #(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int DVSR    = DVSR_DEF
  )
  (
    input  logic           clk,
    input  logic           reset,
    fifo_uart_tx_if.slave  fifo,
    output logic           tx,
    output logic           tx_busy,
    output logic           tx_done_tick
  );

  localparam int SW = $clog2(max_int(SB_TICK, OVS_TICKS));
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] OVS_LAST  = SW'(OVS_TICKS - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] BIT_LAST  = NW'(DBIT - 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            rd_q, rd_d;
  logic            done_q, done_d;
  logic            load;
  logic            s_tick;
`ifdef FIFO_UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  baud_gen #(.DVSR(DVSR)) u_baud_gen (
    .clk    (clk),
    .reset  (reset),
    .clr    (load),
    .s_tick (s_tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    tx_d    = tx_q;
    rd_d    = 1'b0;
    done_d  = 1'b0;
    load    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo.fifo_empty) load = 1'b1;
      end
      START: begin
        if (s_tick) begin
          if (s_q == OVS_LAST) begin
            s_d     = '0;
            state_d = DATA;
            tx_d    = b_q[0];
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == OVS_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == BIT_LAST) begin
              n_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
              state_d = PARITY;
              tx_d    = par_q;
`else
              state_d = STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              n_d  = n_q + 1'b1;
              tx_d = b_d[0];
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == OVS_LAST) begin
            s_d     = '0;
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_q == STOP_LAST) begin
            s_d    = '0;
            done_d = 1'b1;
            tx_d   = 1'b1;
            if (!fifo.fifo_empty) load = 1'b1;
            else state_d = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load overrides everything: latch the head word and start a new frame.
    if (load) begin
      state_d = START;
      b_d     = fifo.fifo_r_data;
      tx_d    = 1'b0;
      rd_d    = 1'b1;
      s_d     = '0;
      n_d     = '0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_d   = ^fifo.fifo_r_data;
`endif
    end
  end

  assign tx           = tx_q;
  assign fifo.fifo_rd = rd_q;
  assign tx_done_tick = done_q;
  assign tx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at DVSR=4 (64-clock bit time).
// Honours FIFO_UART_TX_PARITY_EN to expect the extra parity bit.
module tb_fifo_uart_tx;

`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * 64;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // bit k = line level during frame bit k (start..stop)
    logic       par;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic tx, tx_busy, tx_done_tick;

  fifo_uart_tx_if #(.DBIT(8)) fif ();

  fifo_uart_tx #(.DBIT(8), .SB_TICK(16), .DVSR(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo         (fif),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_pass  = 0;
  int   rd_cnt  = 0;
  int   done_cnt = 0;
  vec_t q[$];
  vec_t tbl[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic fifo_drive();
    if (q.size() > 0) begin
      fif.fifo_empty  = 1'b0;
      fif.fifo_r_data = q[0].data;
    end else begin
      fif.fifo_empty  = 1'b1;
      fif.fifo_r_data = 8'h11;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (fif.fifo_rd) begin
      rd_cnt++;
      if (q.size() > 0) q.delete(0);
      fifo_drive();
    end
    if (tx_done_tick) done_cnt++;
  endtask

  function automatic logic exp_bit(input vec_t v, input int k);
    if (k < 9) return v.line[k];
`ifdef FIFO_UART_TX_PARITY_EN
    if (k == 9) return v.par;
`endif
    return v.line[9];
  endfunction

  // Sends every queued word; frame f is expected to start exactly f*FRAME clocks after the first.
  task automatic send_frames(input int nf);
    vec_t w[$];
    int   rd0, d0, f, o;
    w   = q;
    rd0 = rd_cnt;
    d0  = done_cnt;
    fifo_drive();
    for (int c = 0; c <= nf * FRAME; c++) begin
      step();
      f = c / FRAME;
      o = c % FRAME;
      if (f < nf && o == 0) begin
        check($sformatf("start_tx %0h", w[f].data), {31'd0, tx}, 32'd0);
        check($sformatf("pop %0h", w[f].data), {31'd0, fif.fifo_rd}, 32'd1);
      end
      if (c > 0 && o == 0)
        check($sformatf("done %0h", w[f-1].data), {31'd0, tx_done_tick}, 32'd1);
      if (f < nf && o == FRAME - 1)
        check($sformatf("done_early %0h", w[f].data), {31'd0, tx_done_tick}, 32'd0);
      if (f < nf && o == 100)
        check($sformatf("busy %0h", w[f].data), {31'd0, tx_busy}, 32'd1);
      if (f < nf && (o % 64) == 32)
        check($sformatf("bit%0d of %0h", o / 64, w[f].data), {31'd0, tx},
              {31'd0, exp_bit(w[f], o / 64)});
    end
    check("idle_tx", {31'd0, tx}, 32'd1);
    check("idle_busy", {31'd0, tx_busy}, 32'd0);
    check("pop_count", rd_cnt - rd0, nf);
    check("done_count", done_cnt - d0, nf);
  endtask

  initial begin
    tbl[0] = '{8'hA5, 10'b1101001010, 1'b0};
    tbl[1] = '{8'h00, 10'b1000000000, 1'b0};
    tbl[2] = '{8'hFF, 10'b1111111110, 1'b0};
    tbl[3] = '{8'h55, 10'b1010101010, 1'b0};
    tbl[4] = '{8'h07, 10'b1000001110, 1'b1};
    tbl[5] = '{8'h03, 10'b1000000110, 1'b0};
    tbl[6] = '{8'h3C, 10'b1001111000, 1'b0};
    tbl[7] = '{8'h80, 10'b1100000000, 1'b1};

    reset = 1'b0;
    fifo_drive();
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_rd", {31'd0, fif.fifo_rd}, 32'd0);
      check("rst_busy", {31'd0, tx_busy}, 32'd0);
      check("rst_done", {31'd0, tx_done_tick}, 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 100; i++) step();
    check("idle_no_pop", rd_cnt, 0);
    check("idle_line", {31'd0, tx}, 32'd1);
    check("idle_not_busy", {31'd0, tx_busy}, 32'd0);

    // Single frames; the head word changes to 0x11 right after each pop.
    for (int i = 0; i < 8; i++) begin
      q.push_back(tbl[i]);
      send_frames(1);
    end

    // Three queued words go out back-to-back.
    q.push_back(tbl[1]);
    q.push_back(tbl[2]);
    q.push_back(tbl[3]);
    send_frames(3);

    // Reset 200 clocks into a 0x3C frame.
    q.push_back(tbl[6]);
    fifo_drive();
    for (int c = 0; c < 200; c++) step();
    reset = 1'b0;
    begin
      int rd0, d0;
      step();
      check("abort_tx", {31'd0, tx}, 32'd1);
      check("abort_rd", {31'd0, fif.fifo_rd}, 32'd0);
      check("abort_done", {31'd0, tx_done_tick}, 32'd0);
      check("abort_busy", {31'd0, tx_busy}, 32'd0);
      reset = 1'b1;
      rd0 = rd_cnt;
      d0  = done_cnt;
      for (int c = 0; c < 800; c++) step();
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_no_pop", rd_cnt - rd0, 0);
      check("abort_line", {31'd0, tx}, 32'd1);
    end
    q.push_back(tbl[0]);
    send_frames(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
